pc_sequencer: RTL and testbench

- Owns the program counter of the single-cycle CPU.
- Decides each cycle whether the PC advances normally (PC+4) or is redirected to the branch/jump target, using the flow-control rule OUT = JUMP | (BRANCH & ZERO).
- Holds the PC while either memory reports busy.
- Provides a boot cycle after reset so instruction memory sees a stable reset vector before the first retire.

---
 rtl/pc_sequencer_if.sv | 47 ++++
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the flow-control inputs, memory busywait inputs and the PC / fetch
// status outputs of the program-counter sequencer.
//
// Parameters:
//   ADDR_W    width of PC and PC_PLUS4
//   OFFSET_W  width of the signed word offset
//
// Signals:
//   JUMP, BRANCH, ZERO     flow-control inputs for the current instruction
//   OFFSET                 signed word offset relative to PC+4
//   I_BUSYWAIT, D_BUSYWAIT instruction / data memory not ready
//   PC                     registered fetch address
//   PC_PLUS4               combinational PC+4
//   FETCH_VALID            current instruction may execute / write back
//   STALL                  PC is being held because a memory is busy
//
// Modports:
//   master  drives the inputs and observes the outputs (CPU core / bench)
//   slave   the sequencer itself
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 8
);
    logic                JUMP;
    logic                BRANCH;
    logic                ZERO;
    logic [OFFSET_W-1:0] OFFSET;
    logic                I_BUSYWAIT;
    logic                D_BUSYWAIT;
    logic [ADDR_W-1:0]   PC;
    logic [ADDR_W-1:0]   PC_PLUS4;
    logic                FETCH_VALID;
    logic                STALL;

    modport master (
        output JUMP, BRANCH, ZERO, OFFSET, I_BUSYWAIT, D_BUSYWAIT,
        input  PC, PC_PLUS4, FETCH_VALID, STALL
    );

    modport slave (
        input  JUMP, BRANCH, ZERO, OFFSET, I_BUSYWAIT, D_BUSYWAIT,
        output PC, PC_PLUS4, FETCH_VALID, STALL
    );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the single-cycle CPU. Each retiring edge the PC
// either advances to PC+4 or is redirected to PC+4 + (sign_extend(OFFSET)<<2)
// when JUMP | (BRANCH & ZERO). The PC is held while either memory is busy,
// and one boot cycle follows reset so instruction memory sees a stable reset
// vector before the first retire.
//
// Optional feature (macro PC_PERF_CNT_EN): adds RETIRED_CNT / TAKEN_CNT
// performance counters that count retiring edges and taken redirects.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous active-low reset
//   bus          pc_sequencer_if.slave (flow inputs, busywaits, PC outputs)
//   RETIRED_CNT  (PC_PERF_CNT_EN only) retired instruction count
//   TAKEN_CNT    (PC_PERF_CNT_EN only) taken redirect count
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                OFFSET_W     = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    pc_sequencer_if.slave bus
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]  RETIRED_CNT,
    output logic [31:0]  TAKEN_CNT
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [ADDR_W-1:0]   pc_plus4;
    logic [ADDR_W-1:0]   target;
    logic signed [OFFSET_W-1:0] offset_s;
    logic                busy;
    logic                take;
    logic                retire;
    logic                fetch_valid;
    logic                stall;

    // Branch target: word offset sign-extended to the address width and
    // scaled to bytes; the sum wraps silently modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] calc_target(
        input logic [ADDR_W-1:0]          base,
        input logic signed [OFFSET_W-1:0] off
    );
        logic signed [ADDR_W-1:0] off_ext;
        off_ext     = {{(ADDR_W-OFFSET_W){off[OFFSET_W-1]}}, off};
        calc_target = base + (off_ext <<< 2);
    endfunction

    assign offset_s = bus.OFFSET;
    assign busy     = bus.I_BUSYWAIT | bus.D_BUSYWAIT;
    assign take     = bus.JUMP | (bus.BRANCH & bus.ZERO);
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign target   = calc_target(pc_plus4, offset_s);

    // ---- state / PC register ----
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_BOOT;
            pc_q  <= RESET_VECTOR;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
        end
    end

    // ---- next-state / output decode ----
    // RUN and STALL retire identically once busy drops; they differ only in
    // which state a busy cycle lands in, so the flow inputs are consumed
    // exactly once per retired instruction.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        fetch_valid = 1'b0;
        stall       = 1'b0;
        retire      = 1'b0;
        unique case (state)
            S_BOOT: begin
                state_nxt = S_RUN;
            end
            S_RUN, S_STALL: begin
                fetch_valid = ~busy;
                stall       = busy;
                if (busy) begin
                    state_nxt = S_STALL;
                end else begin
                    retire    = 1'b1;
                    pc_nxt    = take ? target : pc_plus4;
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    assign bus.PC          = pc_q;
    assign bus.PC_PLUS4    = pc_plus4;
    assign bus.FETCH_VALID = fetch_valid;
    assign bus.STALL       = stall;

`ifdef PC_PERF_CNT_EN
    // ---- performance counters ----
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RETIRED_CNT <= '0;
            TAKEN_CNT   <= '0;
        end else if (retire) begin
            RETIRED_CNT <= RETIRED_CNT + 32'd1;
            if (take) begin
                TAKEN_CNT <= TAKEN_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 8;

    logic CLK;
    logic RESET;

    pc_sequencer_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) bus();

`ifdef PC_PERF_CNT_EN
    logic [31:0] RETIRED_CNT;
    logic [31:0] TAKEN_CNT;
`endif

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .RESET_VECTOR(32'h0000_0000),
        .OFFSET_W    (OFFSET_W)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bus.slave)
`ifdef PC_PERF_CNT_EN
        ,
        .RETIRED_CNT(RETIRED_CNT),
        .TAKEN_CNT  (TAKEN_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    // Reference model: PC value, whether the boot cycle is still pending,
    // and the counts of retired / taken instructions.
    logic [31:0] m_pc;
    bit          m_boot;
    logic [31:0] m_ret;
    logic [31:0] m_tak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=0x%08h expected=0x%08h", phase, tag, obs, exp);
        end
    endtask

    // Called on a falling edge: apply inputs, check outputs, advance the
    // model across the rising edge, return on the next falling edge.
    task automatic cyc(input bit j, input bit b, input bit z, input logic [7:0] off,
                       input bit ib, input bit db);
        bit busy;
        bit tk;
        bus.JUMP       = j;
        bus.BRANCH     = b;
        bus.ZERO       = z;
        bus.OFFSET     = off;
        bus.I_BUSYWAIT = ib;
        bus.D_BUSYWAIT = db;
        busy = ib | db;
        #1;
        chk("pc",          bus.PC,                   m_pc);
        chk("pc_plus4",    bus.PC_PLUS4,             m_pc + 32'd4);
        chk("fetch_valid", 32'(bus.FETCH_VALID),     32'(!m_boot && !busy));
        chk("stall",       32'(bus.STALL),           32'(!m_boot && busy));
`ifdef PC_PERF_CNT_EN
        chk("retired_cnt", RETIRED_CNT, m_ret);
        chk("taken_cnt",   TAKEN_CNT,   m_tak);
`endif
        @(posedge CLK);
        if (m_boot) begin
            m_boot = 0;
        end else if (!busy) begin
            tk = j || (b && z);
            if (tk) m_pc = m_pc + 32'd4 + 32'(4 * int'($signed(off)));
            else    m_pc = m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
            if (tk) m_tak = m_tak + 32'd1;
        end
        @(negedge CLK);
    endtask

    // Reset is asserted between clock edges, so the PC change seen 1 time
    // unit later can only come from the asynchronous path.
    task automatic do_reset();
        RESET = 1'b0;
        #1;
        chk("rst_pc",    bus.PC,               32'h0);
        chk("rst_fv",    32'(bus.FETCH_VALID), 32'h0);
        chk("rst_stall", 32'(bus.STALL),       32'h0);
`ifdef PC_PERF_CNT_EN
        chk("rst_retired", RETIRED_CNT, 32'h0);
        chk("rst_taken",   TAKEN_CNT,   32'h0);
`endif
        @(posedge CLK);
        @(negedge CLK);
        RESET  = 1'b1;
        m_pc   = 32'h0;
        m_boot = 1;
        m_ret  = 32'h0;
        m_tak  = 32'h0;
    endtask

    // Retire one jump that lands on an absolute target.
    task automatic goto(input logic [31:0] tgt);
        logic [31:0] diff;
        int          di;
        diff = tgt - (m_pc + 32'd4);
        di   = int'($signed(diff));
        if ((di % 4) != 0 || di / 4 > 127 || di / 4 < -128) begin
            $display("FAIL goto target 0x%08h unreachable from 0x%08h", tgt, m_pc);
            $fatal(1, "unreachable jump target");
        end
        cyc(1, 0, 0, 8'(di / 4), 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET          = 1'b0;
        bus.JUMP       = 1'b0;
        bus.BRANCH     = 1'b0;
        bus.ZERO       = 1'b0;
        bus.OFFSET     = '0;
        bus.I_BUSYWAIT = 1'b0;
        bus.D_BUSYWAIT = 1'b0;
        m_pc = 0; m_boot = 1; m_ret = 0; m_tak = 0;
        @(negedge CLK);

        // 1: boot then sequential fetch
        phase = "t1";
        do_reset();
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        #1 chk("t1_pc_c", bus.PC, 32'h0000_000C);

        // 2: taken / not-taken branch with negative offset
        phase = "t2";
        goto(32'h10);
        cyc(0, 1, 1, 8'hFE, 0, 0);
        #1 chk("t2_taken", bus.PC, 32'h0000_000C);
        goto(32'h10);
        cyc(0, 1, 0, 8'hFE, 0, 0);
        #1 chk("t2_not_taken", bus.PC, 32'h0000_0014);

        // 3: jump wins over a failing branch
        phase = "t3";
        goto(32'h20);
        cyc(1, 1, 0, 8'h03, 0, 0);
        #1 chk("t3_jump", bus.PC, 32'h0000_0030);

        // 4: four stall cycles with a pending jump and a toggling offset
        phase = "t4";
        goto(32'h40);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 8'($urandom), (i == 2), 1);
            chk("t4_hold", bus.PC, 32'h0000_0040);
        end
        cyc(1, 0, 0, 8'h05, 0, 0);
        #1 chk("t4_redirect", bus.PC, 32'h0000_0058);
        cyc(0, 0, 0, 8'h00, 0, 0);
        #1 chk("t4_single", bus.PC, 32'h0000_005C);

        // 5: wrap-around, then reset in the middle of a stall
        phase = "t5";
        do_reset();
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'hFE, 0, 0);
        #1 chk("t5_top", bus.PC, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 8'h00, 0, 0);
        #1 chk("t5_wrap", bus.PC, 32'h0000_0000);
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'h0A, 1, 0);
        cyc(1, 0, 0, 8'h0A, 1, 1);
        do_reset();
        cyc(1, 0, 0, 8'h0A, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        #1 chk("t5_no_redirect", bus.PC, 32'h0000_0004);

`ifdef PC_PERF_CNT_EN
        // 6: 5 retires (2 taken) with 3 stall cycles in between
        phase = "t6";
        do_reset();
        cyc(1, 0, 0, 8'h01, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'h02, 0, 1);
        cyc(1, 0, 0, 8'h02, 0, 0);
        cyc(1, 0, 0, 8'h03, 1, 0);
        cyc(1, 1, 1, 8'h03, 1, 1);
        cyc(0, 1, 0, 8'h04, 0, 0);
        cyc(0, 1, 1, 8'h01, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        #1;
        chk("t6_retired", RETIRED_CNT, 32'd5);
        chk("t6_taken",   TAKEN_CNT,   32'd2);
        do_reset();
`endif

        // 7: randomized traffic against the model
        phase = "rand";
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                cyc(bit'($urandom_range(0, 3) == 0),
                    bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)),
                    8'($urandom),
                    bit'($urandom_range(0, 4) == 0),
                    bit'($urandom_range(0, 4) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
